// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that funnels NUM_PORTS cache line requests onto one memory port.
// One transaction at a time: IDLE picks a port, ACTIVE waits for memory, DONE lets the requester drop.
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int TAG_W     = 27,
  localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [LINE_W-1:0]           req_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [TAG_W-1:0]            mem_tag,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_resp,
  output logic [PTR_W-1:0]            grant_id,
  output logic                        busy,
  output logic [1:0]                  fsm_state
);

  // Handshake: each port holds req_read/req_write until its one-cycle req_resp pulse;
  // memory holds mem_read/mem_write until its one-cycle mem_resp pulse.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       next_ptr;
  logic [NUM_PORTS-1:0]   req_any;
  logic [NUM_PORTS-1:0]   grant_onehot;
  logic [PTR_W:0]         cand;
  logic                   sel_found;
  logic [PTR_W-1:0]       sel_id;
  logic                   sel_read;
  logic                   sel_write;
  logic [TAG_W-1:0]       sel_tag;
  logic [LINE_W-1:0]      sel_wdata;

  assign req_any = req_read | req_write;

  // Search upward from rr_ptr with wrap; cand is one bit wider so the sum cannot overflow.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!sel_found && req_any[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_tag   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_id == PTR_W'(i)) begin
        sel_read  = req_read[i];
        sel_write = req_write[i];
        sel_tag   = req_tag[i*TAG_W +: TAG_W];
        sel_wdata = req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_onehot[i] = (grant_id == PTR_W'(i));
    end
  end

  assign next_ptr = (grant_id == PTR_W'(NUM_PORTS-1)) ? '0 : grant_id + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sel_found) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (mem_resp)  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != ST_IDLE);
    fsm_state = state;
  end

  // Datapath registers; a write wins over a simultaneous read on the selected port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_tag   <= '0;
      mem_wdata <= '0;
      req_resp  <= '0;
      req_rdata <= '0;
    end else begin
      req_resp <= '0;
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            grant_id  <= sel_id;
            mem_tag   <= sel_tag;
            mem_wdata <= sel_wdata;
            mem_write <= sel_write;
            mem_read  <= sel_read & ~sel_write;
          end
        end
        ST_ACTIVE: begin
          if (mem_resp) begin
            req_resp  <= grant_onehot;
            req_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rr_ptr    <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a 2-port and a 4-port instance share clock and reset;
// expected grants are queued when requests are raised and checked when memory sees them.
module tb_mem_arbiter_rr;
  localparam int LW2 = 256;
  localparam int TW2 = 27;
  localparam int LW4 = 64;
  localparam int TW4 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       r2_read, r2_write, resp2;
  logic [2*TW2-1:0] r2_tag;
  logic [2*LW2-1:0] r2_wdata;
  logic [LW2-1:0]   rdata2, m2_wdata, m2_rdata;
  logic             m2_read, m2_write, m2_resp, busy2;
  logic [TW2-1:0]   m2_tag;
  logic [0:0]       gid2;
  logic [1:0]       st2;

  logic [3:0]       r4_read, r4_write, resp4;
  logic [4*TW4-1:0] r4_tag;
  logic [4*LW4-1:0] r4_wdata;
  logic [LW4-1:0]   rdata4, m4_wdata, m4_rdata;
  logic             m4_read, m4_write, m4_resp, busy4;
  logic [TW4-1:0]   m4_tag;
  logic [1:0]       gid4;
  logic [1:0]       st4;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [LW2-1:0] last_rd2;

  mem_arbiter_rr #(.NUM_PORTS(2), .LINE_W(LW2), .TAG_W(TW2)) dut2 (
    .clk(clk), .rst(rst), .req_read(r2_read), .req_write(r2_write), .req_tag(r2_tag),
    .req_wdata(r2_wdata), .req_resp(resp2), .req_rdata(rdata2), .mem_read(m2_read),
    .mem_write(m2_write), .mem_tag(m2_tag), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata),
    .mem_resp(m2_resp), .grant_id(gid2), .busy(busy2), .fsm_state(st2)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .LINE_W(LW4), .TAG_W(TW4)) dut4 (
    .clk(clk), .rst(rst), .req_read(r4_read), .req_write(r4_write), .req_tag(r4_tag),
    .req_wdata(r4_wdata), .req_resp(resp4), .req_rdata(rdata4), .mem_read(m4_read),
    .mem_write(m4_write), .mem_tag(m4_tag), .mem_wdata(m4_wdata), .mem_rdata(m4_rdata),
    .mem_resp(m4_resp), .grant_id(gid4), .busy(busy4), .fsm_state(st4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // {is_write, port[2:0], tag[27:0]}
  function automatic logic [31:0] pack_exp(input logic w, input int port, input logic [27:0] tag);
    return {w, 3'(port), tag};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r2_read = '0; r2_write = '0; m2_resp = 1'b0;
    r4_read = '0; r4_write = '0; m4_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve2(input int lat, input bit drop, output int waited);
    logic [31:0] e;
    logic [LW2-1:0] rd;
    int p;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(m2_read || m2_write) && waited < 20);
    total++;
    if (!(m2_read || m2_write)) begin
      bad++;
      $display("FAIL serve2_issue: no mem request within %0d cycles, required one", waited);
      return;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL serve2_queue: mem request tag=%h with nothing expected", m2_tag);
      return;
    end
    e = exp_q.pop_front();
    p = int'(e[30:28]);
    total++;
    if (gid2 !== e[28] || m2_tag !== e[TW2-1:0] || m2_write !== e[31] || m2_read !== !e[31]) begin
      bad++;
      $display("FAIL serve2_grant: gid=%0d tag=%h rd=%b wr=%b, required gid=%0d tag=%h wr=%b",
               gid2, m2_tag, m2_read, m2_write, p, e[TW2-1:0], e[31]);
    end
    if (e[31]) begin
      total++;
      if (m2_wdata !== r2_wdata[p*LW2 +: LW2]) begin
        bad++;
        $display("FAIL serve2_wdata: got %h, required %h", m2_wdata, r2_wdata[p*LW2 +: LW2]);
      end
    end
    repeat (lat) begin
      @(negedge clk);
      total++;
      if (m2_tag !== e[TW2-1:0] || m2_write !== e[31] || m2_read !== !e[31] || resp2 !== 2'b00) begin
        bad++;
        $display("FAIL serve2_hold: tag=%h rd=%b wr=%b resp=%b, required tag=%h wr=%b resp=00",
                 m2_tag, m2_read, m2_write, resp2, e[TW2-1:0], e[31]);
      end
    end
    for (int i = 0; i < LW2/32; i++) rd[i*32 +: 32] = $urandom();
    m2_rdata = rd;
    m2_resp = 1'b1;
    @(negedge clk);
    m2_resp = 1'b0;
    m2_rdata = '0;
    total++;
    if (resp2 !== (2'b01 << p) || rdata2 !== rd || m2_read !== 1'b0 || m2_write !== 1'b0 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL serve2_resp: resp=%b rdata_ok=%b rd=%b wr=%b busy=%b, required resp=%b rdata_ok=1 rd=0 wr=0 busy=1",
               resp2, rdata2 === rd, m2_read, m2_write, busy2, 2'b01 << p);
    end
    last_rd2 = rd;
    if (drop) begin
      r2_read[p] = 1'b0;
      r2_write[p] = 1'b0;
    end
    @(negedge clk);
    total++;
    if (resp2 !== 2'b00 || rdata2 !== rd || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL serve2_after: resp=%b rdata_ok=%b busy=%b, required resp=00 rdata_ok=1 busy=0",
               resp2, rdata2 === rd, busy2);
    end
  endtask

  task automatic serve4(input int lat, output int waited);
    logic [31:0] e;
    logic [LW4-1:0] rd;
    int p;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(m4_read || m4_write) && waited < 20);
    total++;
    if (!(m4_read || m4_write) || exp_q.size() == 0) begin
      bad++;
      $display("FAIL serve4_issue: req=%b queued=%0d, required a request and an expectation",
               m4_read || m4_write, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    p = int'(e[30:28]);
    total++;
    if (gid4 !== e[29:28] || m4_tag !== e[TW4-1:0] || m4_write !== e[31] || m4_read !== !e[31]) begin
      bad++;
      $display("FAIL serve4_grant: gid=%0d tag=%h rd=%b wr=%b, required gid=%0d tag=%h wr=%b",
               gid4, m4_tag, m4_read, m4_write, p, e[TW4-1:0], e[31]);
    end
    if (e[31]) begin
      total++;
      if (m4_wdata !== r4_wdata[p*LW4 +: LW4]) begin
        bad++;
        $display("FAIL serve4_wdata: got %h, required %h", m4_wdata, r4_wdata[p*LW4 +: LW4]);
      end
    end
    repeat (lat) @(negedge clk);
    rd = {$urandom(), $urandom()};
    m4_rdata = rd;
    m4_resp = 1'b1;
    @(negedge clk);
    m4_resp = 1'b0;
    total++;
    if (resp4 !== (4'b0001 << p) || rdata4 !== rd) begin
      bad++;
      $display("FAIL serve4_resp: resp=%b rdata=%h, required resp=%b rdata=%h", resp4, rdata4, 4'b0001 << p, rd);
    end
    @(negedge clk);
    total++;
    if (resp4 !== 4'b0000 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL serve4_after: resp=%b busy=%b, required 0000 and 0", resp4, busy4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r2_read = '0; r2_write = '0; r2_tag = '0; r2_wdata = '0; m2_rdata = '0; m2_resp = 1'b0;
    r4_read = '0; r4_write = '0; r4_tag = '0; r4_wdata = '0; m4_rdata = '0; m4_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (resp2 !== '0 || rdata2 !== '0 || m2_read !== 1'b0 || m2_write !== 1'b0 || m2_tag !== '0 ||
        m2_wdata !== '0 || gid2 !== '0 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut2: resp=%b rd=%b wr=%b tag=%h gid=%0d busy=%b, required all zero",
               resp2, m2_read, m2_write, m2_tag, gid2, busy2);
    end
    total++;
    if (resp4 !== '0 || rdata4 !== '0 || m4_read !== 1'b0 || m4_write !== 1'b0 || m4_tag !== '0 ||
        m4_wdata !== '0 || gid4 !== '0 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut4: resp=%b rd=%b wr=%b tag=%h gid=%0d busy=%b, required all zero",
               resp4, m4_read, m4_write, m4_tag, gid4, busy4);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int w;
    @(negedge clk);
    r2_tag[TW2 +: TW2] = 27'h1234;
    r2_read = 2'b10;
    exp_q.push_back(pack_exp(1'b0, 1, 28'h1234));
    serve2(3, 1'b1, w);
    total++;
    if (w != 1) begin
      bad++;
      $display("FAIL single_read_latency: mem request after %0d cycles, required 1", w);
    end
  endtask

  task automatic test_contention();
    int w;
    do_reset();
    r2_tag[0 +: TW2] = 27'h0AAA;
    r2_tag[TW2 +: TW2] = 27'h0BBB;
    r2_read = 2'b11;
    exp_q.push_back(pack_exp(1'b0, 0, 28'h0AAA));
    exp_q.push_back(pack_exp(1'b0, 1, 28'h0BBB));
    exp_q.push_back(pack_exp(1'b0, 0, 28'h0AAA));
    serve2($urandom_range(0, 3), 1'b0, w);
    for (int k = 0; k < 2; k++) begin
      serve2($urandom_range(0, 3), 1'b0, w);
      total++;
      if (w != 1) begin
        bad++;
        $display("FAIL back_to_back_%0d: next mem request after %0d cycles, required 1", k, w);
      end
    end
    r2_read = 2'b00;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy2 !== 1'b0 || m2_read !== 1'b0) begin
      bad++;
      $display("FAIL contention_idle: busy=%b rd=%b, required 0 0", busy2, m2_read);
    end
  endtask

  task automatic test_write_with_read();
    int w;
    r2_wdata[0 +: LW2] = {32{8'hA5}};
    r2_tag[0 +: TW2] = 27'h0077;
    r2_read = 2'b01;
    r2_write = 2'b01;
    exp_q.push_back(pack_exp(1'b1, 0, 28'h0077));
    serve2(1, 1'b1, w);
  endtask

  task automatic test_stability();
    int w;
    r2_tag[TW2 +: TW2] = 27'h5555;
    r2_read = 2'b10;
    exp_q.push_back(pack_exp(1'b0, 1, 28'h5555));
    @(negedge clk);
    r2_tag[TW2 +: TW2] = 27'h6666;
    r2_tag[0 +: TW2] = 27'h0101;
    r2_read = 2'b11;
    serve2(3, 1'b1, w);
    exp_q.push_back(pack_exp(1'b0, 0, 28'h0101));
    serve2(2, 1'b1, w);
    @(negedge clk);
    m2_rdata = {LW2/32{32'hDEADBEEF}};
    m2_resp = 1'b1;
    @(negedge clk);
    m2_resp = 1'b0;
    total++;
    if (resp2 !== 2'b00 || busy2 !== 1'b0 || rdata2 !== last_rd2) begin
      bad++;
      $display("FAIL spurious_resp: resp=%b busy=%b rdata_kept=%b, required 00 0 1",
               resp2, busy2, rdata2 === last_rd2);
    end
    @(negedge clk);
    total++;
    if (st2 !== 2'd0 || resp2 !== 2'b00) begin
      bad++;
      $display("FAIL spurious_state: state=%0d resp=%b, required 0 00", st2, resp2);
    end
  endtask

  task automatic test_reset_mid_active();
    int w;
    r2_tag[TW2 +: TW2] = 27'h0321;
    r2_read = 2'b10;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m2_read !== 1'b1 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL mid_active_setup: rd=%b busy=%b, required 1 1", m2_read, busy2);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (m2_read !== 1'b0 || m2_write !== 1'b0 || m2_tag !== '0 || m2_wdata !== '0 ||
        busy2 !== 1'b0 || gid2 !== '0 || resp2 !== '0 || rdata2 !== '0) begin
      bad++;
      $display("FAIL async_reset: rd=%b tag=%h busy=%b gid=%0d resp=%b, required all zero",
               m2_read, m2_tag, busy2, gid2, resp2);
    end
    m2_resp = 1'b1;
    @(negedge clk);
    m2_resp = 1'b0;
    @(negedge clk);
    total++;
    if (resp2 !== 2'b00 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_resp: resp=%b busy=%b, required 00 0", resp2, busy2);
    end
    rst = 1'b0;
    r2_tag[0 +: TW2] = 27'h0400;
    r2_read = 2'b11;
    exp_q.push_back(pack_exp(1'b0, 0, 28'h0400));
    exp_q.push_back(pack_exp(1'b0, 1, 28'h0321));
    serve2(1, 1'b1, w);
    serve2(0, 1'b1, w);
  endtask

  task automatic test_rr4();
    int w;
    for (int i = 0; i < 4; i++) begin
      r4_tag[i*TW4 +: TW4] = 16'h0100 + 16'(i);
      r4_wdata[i*LW4 +: LW4] = {$urandom(), $urandom()};
    end
    r4_read = 4'hF;
    r4_write = 4'b0100;
    exp_q.push_back(pack_exp(1'b0, 0, 28'h100));
    exp_q.push_back(pack_exp(1'b0, 1, 28'h101));
    exp_q.push_back(pack_exp(1'b1, 2, 28'h102));
    exp_q.push_back(pack_exp(1'b0, 3, 28'h103));
    exp_q.push_back(pack_exp(1'b0, 0, 28'h100));
    for (int k = 0; k < 5; k++) begin
      serve4($urandom_range(0, 4), w);
      if (k > 0) begin
        total++;
        if (w != 1) begin
          bad++;
          $display("FAIL rr4_back_to_back_%0d: waited %0d cycles, required 1", k, w);
        end
      end
    end
    r4_read = '0;
    r4_write = '0;
  endtask

  task automatic test_random2();
    int w;
    int p;
    logic wr;
    logic [TW2-1:0] t;
    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      t = 27'($urandom());
      r2_tag[p*TW2 +: TW2] = t;
      r2_tag[(1-p)*TW2 +: TW2] = 27'($urandom());
      r2_wdata[p*LW2 +: LW2] = {LW2/32{$urandom()}};
      r2_read = '0;
      r2_write = '0;
      r2_read[p] = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r2_write[p] = wr;
      exp_q.push_back(pack_exp(wr, p, 28'(t)));
      serve2($urandom_range(0, 4), 1'b1, w);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_with_read();
    test_stability();
    test_reset_mid_active();
    test_rr4();
    test_random2();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesting caches; legal range 2..8.
REQ-002 Parameter LINE_W, default 256: cache line width in bits.
REQ-003 Parameter TAG_W, default 27: line address (tag) width in bits.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_read  input  NUM_PORTS  per-port line read request; held until that port's req_resp.
REQ-007 req_write  input  NUM_PORTS  per-port line write request; held until that port's req_resp.
REQ-008 req_tag  input  NUM_PORTS*TAG_W  per-port line address; port i occupies bits [i*TAG_W +: TAG_W].
REQ-009 req_wdata  input  NUM_PORTS*LINE_W  per-port write line; port i occupies bits [i*LINE_W +: LINE_W].
REQ-010 req_resp  output  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-011 req_rdata  output  LINE_W  read line broadcast to all ports; valid while req_resp is high.
REQ-012 mem_read / mem_write  output  1 each  registered request to the next memory level.
REQ-013 mem_tag  output  TAG_W  registered address to memory.
REQ-014 mem_wdata  output  LINE_W  registered write line to memory.
REQ-015 mem_rdata  input  LINE_W  read line from memory; valid with mem_resp.
REQ-016 mem_resp  input  1  memory completion; high one cycle.
REQ-017 grant_id  output  $clog2(NUM_PORTS)  index of the currently or last granted port.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, ACTIVE, DONE.
REQ-020 A port is requesting when req_read[i] or req_write[i] is high.
REQ-021 IDLE with no port requesting: remain in IDLE; mem_read and mem_write stay 0.
REQ-022 IDLE with one or more ports requesting: select the first requesting port starting at rr_ptr and searching upward with wrap-around modulo NUM_PORTS.
REQ-023 On that edge: latch grant_id; register mem_tag and mem_wdata from the selected port; move to ACTIVE.
REQ-024 mem_read/mem_write are asserted on the cycle after the request is first seen (one-cycle issue latency).
REQ-025 Selected port with both req_read and req_write high: issue a write (mem_write=1, mem_read=0); the read is ignored.
REQ-026 ACTIVE: hold mem_read, mem_write, mem_tag and mem_wdata stable; ignore changes on all request inputs, including those of the granted port.
REQ-027 ACTIVE with mem_resp=1 at edge k: at k+1, req_resp[grant_id]=1 for exactly one cycle, req_rdata=mem_rdata captured at k, and mem_read=mem_write=0.
REQ-028 On that same edge: rr_ptr = (grant_id+1) mod NUM_PORTS; move to DONE.
REQ-029 DONE lasts one cycle, then returns to IDLE; no arbitration occurs in DONE, which gives the requester a cycle to drop its request.
REQ-030 req_rdata holds its last captured value until the next mem_resp.
REQ-031 Round-robin bound: a continuously requesting port is granted within NUM_PORTS grants.
REQ-032 Only one bit of req_resp is ever high, and only the bit of grant_id.
REQ-033 mem_resp outside ACTIVE is ignored: no req_resp, and no state change.
REQ-034 Back-to-back: after DONE, the next grant issues mem request two cycles after the previous mem_resp.

Reset
REQ-035 rst high (asynchronous) forces: state=IDLE, rr_ptr=0, grant_id=0, busy=0, mem_read=0, mem_write=0, mem_tag=0, mem_wdata=0, req_resp=0, req_rdata=0.
REQ-036 rst asserted mid-transaction abandons that transaction with no req_resp; the first grant after reset follows REQ-022 with rr_ptr=0.

Verification
REQ-037 Single read: NUM_PORTS=2; port1 req_read, tag 0x1234; mem_resp 3 cycles after mem_read -> mem_read=1 with mem_tag=0x1234 one cycle after request; req_resp=2'b10 for one cycle with req_rdata=mem_rdata; busy drops two cycles after mem_resp.
REQ-038 Contention: ports 0 and 1 request on the same cycle after reset -> port 0 served first, then port 1, then port 0 again if still requesting.
REQ-039 NUM_PORTS=4, all ports always requesting -> grant order 0,1,2,3,0; mem_tag always matches the granted port.
REQ-040 Write with read: port 0 with req_read=req_write=1, wdata=0xA5.. -> mem_write=1, mem_read=0, mem_wdata=0xA5.., req_resp[0] pulse.
REQ-041 Stability: a port's tag changes during ACTIVE, and a spurious mem_resp arrives in IDLE -> mem_tag is unchanged; no req_resp is produced.
REQ-042 Reset mid-ACTIVE -> all outputs zero immediately without waiting for a clock edge; no req_resp; port 0 has priority on the next grant.
